// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtractor_pkg
// Shared types for the digit-serial subtractor: the controller state encoding.
// -----------------------------------------------------------------------------
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_sub_digit.sv
// -----------------------------------------------------------------------------
// sub_digit
// Purely combinational DIGIT-bit subtract with borrow: a - b - borrow_in.
// Ports:
//   a, b        : DIGIT-bit operand slices (unsigned)
//   borrow_in   : borrow from the previous (less significant) digit
//   diff        : DIGIT-bit difference
//   borrow_out  : borrow into the next (more significant) digit
// -----------------------------------------------------------------------------
module sub_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             borrow_in,
    output logic [DIGIT-1:0] diff,
    output logic             borrow_out
);

    logic [DIGIT:0] full;

    // One extra bit catches the wrap: it is set exactly when a < b + borrow_in.
    assign full = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, borrow_in};
    assign {borrow_out, diff} = full;

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Digit-serial unsigned subtractor: diff = (a - b) mod 2^WIDTH, borrow = a < b.
// Processes DIGIT bits per cycle over N = WIDTH/DIGIT cycles, LSB digit first.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready_o=1, waiting for operands
// BUSY  | one digit subtracted per cycle, step counter 0..N-1
// DONE  | valid_o=1, result held until downstream accepts
//
// Ports:
//   clk_i, rst_ni     : clock, async active-low reset
//   valid_i, ready_o  : operand handshake
//   a_i, b_i          : minuend / subtrahend (unsigned, WIDTH bits)
//   valid_o, ready_i  : result handshake
//   diff_o, borrow_o  : result and final borrow (valid only while valid_o=1)
// -----------------------------------------------------------------------------
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if ((WIDTH % DIGIT) != 0 || DIGIT < 1) begin : g_bad_digit
        $error("serial_subtractor: DIGIT must divide WIDTH");
    end

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] diff_r;
    logic [WIDTH-1:0] diff_next;
    logic             borrow_r;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] dig_diff;
    logic             dig_borrow;
    logic             accept;

    assign ready_o  = (state == ST_IDLE);
    assign valid_o  = (state == ST_DONE);
    assign diff_o   = diff_r;
    assign borrow_o = borrow_r;
    assign accept   = valid_i && ready_o;

    sub_digit #(
        .DIGIT (DIGIT)
    ) u_sub_digit (
        .a          (a_sh[DIGIT-1:0]),
        .b          (b_sh[DIGIT-1:0]),
        .borrow_in  (borrow_r),
        .diff       (dig_diff),
        .borrow_out (dig_borrow)
    );

    // New digits enter at the MSB end; after N steps the first (LSB) digit
    // has walked down to bit 0. A single-digit configuration has no shift.
    if (DIGIT == WIDTH) begin : g_one_digit
        assign diff_next = dig_diff;
    end else begin : g_multi_digit
        assign diff_next = {dig_diff, diff_r[WIDTH-1:DIGIT]};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept)        state_next = ST_BUSY;
            ST_BUSY: if (cnt == LAST)   state_next = ST_DONE;
            ST_DONE: if (ready_i)       state_next = ST_IDLE;
            default:                    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_sh     <= '0;
            b_sh     <= '0;
            diff_r   <= '0;
            borrow_r <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        a_sh     <= a_i;
                        b_sh     <= b_i;
                        borrow_r <= 1'b0;
                        cnt      <= '0;
                    end
                end
                ST_BUSY: begin
                    a_sh     <= a_sh >> DIGIT;
                    b_sh     <= b_sh >> DIGIT;
                    diff_r   <= diff_next;
                    borrow_r <= dig_borrow;
                    if (cnt != LAST) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    typedef struct {
        logic [7:0] d;
        logic       b;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic       v1, r1, rdy1, vo1, bo1;
    logic [7:0] a1, b1, d1;
    logic       v4, r4, rdy4, vo4, bo4;
    logic [7:0] a4, b4, d4;

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(v1), .ready_o(rdy1),
        .a_i(a1), .b_i(b1), .valid_o(vo1), .ready_i(r1),
        .diff_o(d1), .borrow_o(bo1)
    );

    serial_subtractor #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(v4), .ready_o(rdy4),
        .a_i(a4), .b_i(b4), .valid_o(vo4), .ready_i(r4),
        .diff_o(d4), .borrow_o(bo4)
    );

    exp_t q1[$];
    exp_t q4[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Reference: plain modular arithmetic and unsigned compare.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.d = 8'((int'(a) - int'(b) + 256) % 256);
        e.b = (a < b);
        return e;
    endfunction

    function automatic logic rdy_of(input int w);
        return (w == 1) ? rdy1 : rdy4;
    endfunction

    function automatic logic vo_of(input int w);
        return (w == 1) ? vo1 : vo4;
    endfunction

    // Monitors: pop and compare on every output handshake.
    always @(negedge clk) begin
        if (rst_n && vo1 && r1) begin
            if (q1.size() == 0) begin
                chk("d1_unexpected_result", {24'd0, d1}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("d1_diff", {24'd0, d1}, {24'd0, e.d});
                chk("d1_borrow", {31'd0, bo1}, {31'd0, e.b});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && vo4 && r4) begin
            if (q4.size() == 0) begin
                chk("d4_unexpected_result", {24'd0, d4}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q4.pop_front();
                chk("d4_diff", {24'd0, d4}, {24'd0, e.d});
                chk("d4_borrow", {31'd0, bo4}, {31'd0, e.b});
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge with
    // valid_i still asserted.
    task automatic send(input int w, input logic [7:0] a, input logic [7:0] b,
                        output int acc_cyc);
        int n = 0;
        if (w == 1) begin a1 = a; b1 = b; v1 = 1'b1; end
        else        begin a4 = a; b4 = b; v4 = 1'b1; end
        while (!rdy_of(w) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            timeout("accept");
            acc_cyc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (w == 1) q1.push_back(model(a, b));
        else        q4.push_back(model(a, b));
        @(negedge clk);
    endtask

    // Counts clock edges from acceptance until valid_o is seen.
    task automatic latency(input int w, output int n);
        n = 0;
        while (!vo_of(w) && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_idle(input int w);
        int n = 0;
        while (!rdy_of(w) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout("wait_idle");
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, prev, n;
        logic [7:0] cap_d;
        logic       cap_b;
        logic       seen;

        rst_n = 1'b0;
        v1 = 0; r1 = 1; a1 = 0; b1 = 0;
        v4 = 0; r4 = 1; a4 = 0; b4 = 0;
        #1;
        chk("reset_ready", {31'd0, rdy1}, 32'd1);
        chk("reset_valid", {31'd0, vo1}, 32'd0);
        chk("reset_diff", {24'd0, d1}, 32'd0);
        chk("reset_borrow", {31'd0, bo1}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 5 - 3: latency and ready return
        send(1, 8'd5, 8'd3, acc);
        v1 = 0;
        latency(1, n);
        chk("latency_d1", n, 32'd8);
        @(negedge clk);
        chk("ready_back", {31'd0, rdy1}, 32'd1);
        chk("valid_drop", {31'd0, vo1}, 32'd0);

        send(1, 8'd3, 8'd5, acc);    v1 = 0; wait_idle(1);
        send(1, 8'd0, 8'd1, acc);    v1 = 0; wait_idle(1);
        send(1, 8'h80, 8'h80, acc);  v1 = 0; wait_idle(1);

        // Backpressure with valid_i and fresh operands held throughout
        r1 = 0;
        send(1, 8'h33, 8'h51, acc);
        latency(1, n);
        if (n >= 50) timeout("bp_done");
        cap_d = d1;
        cap_b = bo1;
        chk("bp_diff_value", {24'd0, cap_d}, 32'hE2);
        chk("bp_borrow_value", {31'd0, cap_b}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            a1 = 8'($urandom);
            b1 = 8'($urandom);
            @(negedge clk);
            chk("bp_diff_stable", {24'd0, d1}, {24'd0, cap_d});
            chk("bp_borrow_stable", {31'd0, bo1}, {31'd0, cap_b});
            chk("bp_ready_low", {31'd0, rdy1}, 32'd0);
            chk("bp_valid_high", {31'd0, vo1}, 32'd1);
        end
        r1 = 1;
        @(negedge clk);
        v1 = 0;
        chk("bp_release_ready", {31'd0, rdy1}, 32'd1);
        chk("bp_release_valid", {31'd0, vo1}, 32'd0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (vo1) seen = 1;
        end
        chk("bp_no_capture", {31'd0, seen}, 32'd0);

        // Reset at BUSY step 3
        send(1, 8'h77, 8'h12, acc);
        v1 = 0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", {31'd0, vo1}, 32'd0);
        chk("rst_ready", {31'd0, rdy1}, 32'd1);
        q1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (vo1) seen = 1;
        end
        chk("rst_no_result", {31'd0, seen}, 32'd0);
        send(1, 8'd9, 8'd4, acc);
        v1 = 0;
        wait_idle(1);

        // Back-to-back stream, DIGIT=1
        prev = -1;
        for (int i = 0; i < 20; i++) begin
            send(1, 8'($urandom), 8'($urandom), acc);
            if (i > 0) chk("period_d1", acc - prev, 32'd10);
            prev = acc;
        end
        v1 = 0;
        wait_idle(1);

        // DIGIT=4
        send(4, 8'hA5, 8'h5A, acc);
        v4 = 0;
        latency(4, n);
        chk("latency_d4", n, 32'd2);
        chk("d4_direct_diff", {24'd0, d4}, 32'h4B);
        wait_idle(4);

        prev = -1;
        for (int i = 0; i < 10; i++) begin
            send(4, 8'($urandom), 8'($urandom), acc);
            if (i > 0) chk("period_d4", acc - prev, 32'd4);
            prev = acc;
        end
        v4 = 0;
        wait_idle(4);

        repeat (5) @(negedge clk);
        chk("q1_drained", q1.size(), 32'd0);
        chk("q4_drained", q4.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
